// File: rtl/serializer_param_if.sv
// serializer_param_if: word-in / bit-out bus of the parametrised serializer.
// The master side supplies the parallel word, its handshake and the bit-rate
// strobe; the slave side (the serializer) returns din_ready and the framed
// serial stream.
interface serializer_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             msb_first;
    logic             din_ready;
    logic             bit_en;
    logic             dout;
    logic             dout_valid;
    logic             dout_last;

    modport master (
        output din, din_valid, msb_first, bit_en,
        input  din_ready, dout, dout_valid, dout_last
    );

    modport slave (
        input  din, din_valid, msb_first, bit_en,
        output din_ready, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/serializer_param.sv
// serializer_param: WIDTH-bit parallel-to-serial converter with valid/ready
// word input, per-word bit order and a bit_en rate strobe. Outputs are
// registered; din_ready opens in IDLE or on the final bit of a frame with
// bit_en, so back-to-back words stream without a gap.
// Optional feature: define SERIALIZER_PARITY_EN to append one parity bit per
// frame (even parity, or odd when ODD_PARITY = 1).
module serializer_param #(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    serializer_param_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (WIDTH < 2 || (ODD_PARITY != 0 && ODD_PARITY != 1)) begin : g_param_check
        $error("serializer_param: WIDTH must be >= 2 and ODD_PARITY 0 or 1");
    end

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             msb_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             dout_q;
    logic             valid_q;
    logic             last_q;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q;
`endif

    logic ready;
    logic xfer;
    logic first_bit;
    logic next_bit;

    // Handshake window and the bit selected for the next presentation.
    always_comb begin
        ready     = (state == IDLE) | (last_q & bus.bit_en);
        xfer      = bus.din_valid & ready;
        first_bit = bus.msb_first ? bus.din[WIDTH-1] : bus.din[0];
        next_bit  = msb_q ? sreg[WIDTH-2] : sreg[1];
    end

    assign bus.din_ready  = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_last  = last_q;

    // Frame FSM: load on transfer, advance one bit per enabled cycle, end or
    // reload on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            msb_q   <= 1'b0;
            bit_cnt <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (xfer) begin
            state   <= SHIFT;
            sreg    <= bus.din;
            msb_q   <= bus.msb_first;
            bit_cnt <= CNT_LOAD;
            dout_q  <= first_bit;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= (^bus.din) ^ (ODD_PARITY != 0);
`endif
        end else if (bus.bit_en) begin
            case (state)
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        sreg    <= msb_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                        dout_q  <= next_bit;
                        bit_cnt <= bit_cnt - CNT_ONE;
`ifndef SERIALIZER_PARITY_EN
                        last_q  <= (bit_cnt == CNT_ONE);
`endif
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        state   <= PAR;
                        dout_q  <= par_q;
                        last_q  <= 1'b1;
`else
                        state   <= IDLE;
                        dout_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
`endif
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PAR: begin
                    state   <= IDLE;
                    dout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/serializer_param.md
# serializer_param

Parametrised parallel-to-serial converter, the next generation of the team's fixed 4-bit serializer. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, LSB-first or MSB-first, selected per word. Framing flags (`dout_valid`, `dout_last`) and back-to-back word acceptance let it drive serial links and test pattern outputs without gaps.

## Interface
- `WIDTH`, default 8: data word width, legal range ≥ 2.
- `ODD_PARITY`, default 0: parity sense (0 = even, 1 = odd). Used only when `SERIALIZER_PARITY_EN` is defined.
- Local `CNT_W = $clog2(WIDTH+1)`: width of the bit counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` and `msb_first` are valid.
- `msb_first`  in  1  bit order, sampled with the word: 1 = MSB first, 0 = LSB first.
- `din_ready`  out  1  block can accept a word this cycle.
- `bit_en`  in  1  bit-rate strobe: the serial stream advances only on cycles with `bit_en` = 1.
- `dout`  out  1  serial data, registered.
- `dout_valid`  out  1  high while a frame bit is presented on `dout`, registered.
- `dout_last`  out  1  high while the final bit of the frame is presented, registered.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits being presented.
  - PAR: parity bit being presented; this state exists only with the macro.
- Transfer occurs on a rising edge with `din_valid` && `din_ready`.
- `din_ready` is combinational from registered state: `din_ready = (state==IDLE) | (dout_last & bit_en)`.
- IDLE + transfer:
  - Load the shift register from `din`, latch `msb_first`, set `bit_cnt = WIDTH-1`.
  - Present the first bit (`din[0]` or `din[WIDTH-1]`) and go to SHIFT.
  - `bit_en` is not required for the load.
- SHIFT with `bit_en` = 1 and `bit_cnt` > 0: shift toward the selected end, present the next bit, decrement `bit_cnt`.
- SHIFT with `bit_en` = 0: `dout`, `dout_valid`, `dout_last`, the shift register and `bit_cnt` all hold.
- `dout_last` asserts together with the bit that makes `bit_cnt` = 0. Without the macro this is the final data bit.
- Final bit + `bit_en` = 1:
  - With a transfer: reload and present the new word's first bit. No idle cycle is inserted.
  - Without a transfer: go to IDLE with `dout_valid` = 0, `dout_last` = 0, `dout` = 0.
- A new word is never accepted mid-frame. `din_valid` outside the `din_ready` window is held off and does not corrupt the frame.
- `din` is not required to stay stable after the transfer.
- A frame is always exactly WIDTH enabled bit-times, plus 1 with parity.

## Timing
- Reset values (asserted or released): state IDLE, `dout` = 0, `dout_valid` = 0, `dout_last` = 0, `bit_cnt` = 0, shift register = 0. `din_ready` reads 1.
- Reset mid-frame aborts the frame immediately and asynchronously. No partial bits follow after release.
- Latency: the first bit appears on `dout` in the cycle after the transfer edge.
- With `bit_en` tied to 1, bit k of the frame (k = 0..WIDTH-1) appears k+1 cycles after the transfer.
- Throughput with continuous `bit_en` and `din_valid`: one word per WIDTH cycles (WIDTH+1 with parity), and `dout_valid` stays continuously high.
- The bit counter never wraps. `bit_cnt` = 0 with `bit_en` = 1 always ends the frame.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - PAR state is compiled in.
  - After the last data bit, one parity bit is presented: XOR of the word, inverted if `ODD_PARITY` = 1.
  - `dout_last` moves to the parity bit, and the `din_ready` window is the parity bit with `bit_en`.
  - Parity is computed from the word captured at load.
- Undefined: no PAR state and no parity logic. Frames are WIDTH bits. `ODD_PARITY` is ignored.

## Test plan
- WIDTH=8, reset, then transfer `8'hC1` with `msb_first`=0 and `bit_en`=1 → `dout` = 1,0,0,0,0,0,1,1 on cycles 1–8; `dout_last` only on cycle 8; IDLE with `dout_valid`=0 on cycle 9.
- Same stimulus with `msb_first`=1 → `dout` = 1,1,0,0,0,0,0,1.
- `8'hC1` then `8'h3C` back-to-back with `din_valid` held high → 16 consecutive valid bits with no gap; `din_ready` high only in cycle 0 and cycle 8.
- `bit_en` pattern 1,0,0,1,... during `8'hC1` → each bit holds through the low cycles; the frame completes after 8 enabled cycles; `din_valid` held during the frame is not accepted early.
- Drive `rst_n` low at bit 4 of `8'hFF` → `dout`/`dout_valid`/`dout_last` drop to 0 immediately; after release, the next transfer of `8'h01` serializes cleanly.
- Macro defined, `ODD_PARITY`=0, `8'hC1` LSB-first → 9 bits 1,0,0,0,0,0,1,1,1 with `dout_last` on bit 9; `ODD_PARITY`=1 gives 0 as bit 9.
